// File: rtl/flat_loader_if.sv
// Bundle of the pooled-stream input, FC memory write port and FC control
// handshake between the last pooling stage, flat_loader and the FC top.
interface flat_loader_if;
  logic        frame_start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        flat_we;
  logic [15:0] flat_value;
  logic [15:0] flat_addr;
  logic        fc_enable;
  logic        fc_all_end;
  logic        busy;
  logic        frame_done;
  logic        err_len;
  logic [1:0]  state_dbg;

  modport slave (
    input  frame_start, in_valid, in_data, in_last, fc_all_end,
    output in_ready, flat_we, flat_value, flat_addr, fc_enable,
           busy, frame_done, err_len, state_dbg
  );

  modport master (
    output frame_start, in_valid, in_data, in_last, fc_all_end,
    input  in_ready, flat_we, flat_value, flat_addr, fc_enable,
           busy, frame_done, err_len, state_dbg
  );
endinterface

// File: rtl/flat_loader.sv
// Reorders a pixel-major, channel-interleaved pooled stream into channel-major
// flatten order in FC memory, then enables the FC stage until it reports done.
module flat_loader #(
  parameter int CH        = 2,
  parameter int PIX       = 7,
  parameter int ADDR_BASE = 0,
  parameter int RELU      = 1
) (
  input  logic          clk,
  input  logic          reset,
  flat_loader_if.slave  bus
);

  localparam int CW = (CH  > 1) ? $clog2(CH)  : 1;
  localparam int PW = (PIX > 1) ? $clog2(PIX) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [15:0] cbase_q, cbase_d;
  logic        we_q, we_d;
  logic [15:0] value_q, value_d;
  logic [15:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic        done_q, done_d;

  logic        accept;
  logic        last_beat;

  // A beat transfers on in_valid & in_ready; in_ready is high only in LOAD and
  // valid without ready is simply dropped, never counted.
  assign accept    = (state_q == LOAD) && bus.in_valid;
  assign last_beat = (ch_q == CW'(CH - 1)) && (pix_q == PW'(PIX - 1));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    cbase_d = cbase_q;
    we_d    = 1'b0;
    value_d = value_q;
    addr_d  = addr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        ch_d    = '0;
        pix_d   = '0;
        cbase_d = '0;
        if (bus.frame_start) begin
          state_d = LOAD;
          err_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          value_d = ((RELU != 0) && bus.in_data[15]) ? 16'h0000 : bus.in_data;
          addr_d  = 16'(ADDR_BASE) + cbase_q + 16'(pix_q);
          // cbase tracks c*PIX so the channel-major address needs no multiplier
          if (ch_q == CW'(CH - 1)) begin
            ch_d    = '0;
            cbase_d = '0;
            pix_d   = pix_q + 1'b1;
          end else begin
            ch_d    = ch_q + 1'b1;
            cbase_d = cbase_q + 16'(PIX);
          end
          if (last_beat) begin
            state_d = FLUSH;
            if (!bus.in_last) err_d = 1'b1;
          end else if (bus.in_last) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      FLUSH: state_d = RUN;
      RUN: begin
        if (bus.fc_all_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      cbase_q <= '0;
      we_q    <= 1'b0;
      value_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      cbase_q <= cbase_d;
      we_q    <= we_d;
      value_q <= value_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // The write pulse lives only in LOAD/FLUSH/early-end IDLE, so it never
  // overlaps fc_enable, which the FC top uses to pick its memory port.
  assign bus.in_ready   = (state_q == LOAD);
  assign bus.fc_enable  = (state_q == RUN);
  assign bus.busy       = (state_q != IDLE);
  assign bus.flat_we    = we_q;
  assign bus.flat_value = value_q;
  assign bus.flat_addr  = addr_q;
  assign bus.frame_done = done_q;
  assign bus.err_len    = err_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_flat_loader.sv
// Directed bench for flat_loader: vector tables for whole frames, a write
// scoreboard, and hand-written sequences for reset and length errors.
module tb_flat_loader;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [15:0] addr;
    logic [15:0] val;
  } vec_t;

  logic clk;
  logic reset;
  int   tests;
  int   failed;
  logic [31:0] exp_q[$];
  vec_t nom[14];
  vec_t relu_v[14];
  vec_t cur[14];
  logic [15:0] addr_tab[14] = '{16'd0, 16'd7, 16'd1, 16'd8, 16'd2, 16'd9, 16'd3,
                                16'd10, 16'd4, 16'd11, 16'd5, 16'd12, 16'd6, 16'd13};
  bit   chk_nr;

  flat_loader_if fi ();
  flat_loader_if fi_nr ();

  flat_loader #(.CH(2), .PIX(7), .ADDR_BASE(0), .RELU(1)) dut (
    .clk(clk), .reset(reset), .bus(fi.slave)
  );

  flat_loader #(.CH(2), .PIX(7), .ADDR_BASE(0), .RELU(0)) dut_nr (
    .clk(clk), .reset(reset), .bus(fi_nr.slave)
  );

  assign fi_nr.frame_start = fi.frame_start;
  assign fi_nr.in_valid    = fi.in_valid;
  assign fi_nr.in_data     = fi.in_data;
  assign fi_nr.in_last     = fi.in_last;
  assign fi_nr.fc_all_end  = fi.fc_all_end;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the next expected {addr, value}.
  always @(negedge clk) begin
    if (fi.flat_we === 1'b1) begin
      check("we_vs_enable", {31'b0, fi.fc_enable}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr %0h value %0h expected no write",
                 fi.flat_addr, fi.flat_value);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {16'b0, fi.flat_addr}, {16'b0, e[31:16]});
        check("wr_value", {16'b0, fi.flat_value}, {16'b0, e[15:0]});
      end
    end
  end

  task automatic start_frame();
    fi.frame_start = 1'b1;
    step();
    fi.frame_start = 1'b0;
    check("start_ready", {31'b0, fi.in_ready}, 32'd1);
  endtask

  task automatic load_beats(input int n, input bit gapped);
    for (int i = 0; i < n; i++) exp_q.push_back({cur[i].addr, cur[i].val});
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          fi.in_valid = 1'b0;
          fi.in_data  = 16'($urandom);
          step();
        end
      end
      fi.in_valid = 1'b1;
      fi.in_data  = cur[i].data;
      fi.in_last  = cur[i].last;
      step();
      fi.in_valid = 1'b0;
      fi.in_last  = 1'b0;
      if (chk_nr) begin
        check("nr_value", {16'b0, fi_nr.flat_value}, {16'b0, cur[i].data});
        check("nr_addr", {16'b0, fi_nr.flat_addr}, {16'b0, cur[i].addr});
      end
    end
  endtask

  // Called in the FLUSH cycle right after the last accept.
  task automatic complete_frame();
    check("flush_no_enable", {31'b0, fi.fc_enable}, 32'd0);
    check("flush_not_ready", {31'b0, fi.in_ready}, 32'd0);
    step();
    check("enable_rise", {31'b0, fi.fc_enable}, 32'd1);
    check("hold_addr", {16'b0, fi.flat_addr}, {16'b0, cur[13].addr});
    check("hold_value", {16'b0, fi.flat_value}, {16'b0, cur[13].val});
    fi.frame_start = 1'b1;
    fi.in_valid    = 1'b1;
    check("run_not_ready", {31'b0, fi.in_ready}, 32'd0);
    step();
    fi.frame_start = 1'b0;
    fi.in_valid    = 1'b0;
    check("run_state_kept", {30'b0, fi.state_dbg}, 32'd3);
    fi.fc_all_end = 1'b1;
    step();
    fi.fc_all_end = 1'b0;
    check("end_enable_low", {31'b0, fi.fc_enable}, 32'd0);
    check("end_done", {31'b0, fi.frame_done}, 32'd1);
    check("end_busy_low", {31'b0, fi.busy}, 32'd0);
    step();
    check("done_pulse", {31'b0, fi.frame_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'b0, fi.in_ready}, 32'd0);
    check({tag, "_we"}, {31'b0, fi.flat_we}, 32'd0);
    check({tag, "_enable"}, {31'b0, fi.fc_enable}, 32'd0);
    check({tag, "_busy"}, {31'b0, fi.busy}, 32'd0);
    check({tag, "_done"}, {31'b0, fi.frame_done}, 32'd0);
    check({tag, "_err"}, {31'b0, fi.err_len}, 32'd0);
    check({tag, "_value"}, {16'b0, fi.flat_value}, 32'd0);
    check({tag, "_addr"}, {16'b0, fi.flat_addr}, 32'd0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    chk_nr = 1'b0;
    for (int i = 0; i < 14; i++) begin
      nom[i].data = 16'(i);
      nom[i].last = (i == 13);
      nom[i].addr = addr_tab[i];
      nom[i].val  = 16'(i);
      relu_v[i].data = (i % 2 == 0) ? 16'hFFF0 : 16'h0005;
      relu_v[i].last = (i == 13);
      relu_v[i].addr = addr_tab[i];
      relu_v[i].val  = (i % 2 == 0) ? 16'h0000 : 16'h0005;
    end
    fi.frame_start = 1'b0;
    fi.in_valid    = 1'b0;
    fi.in_data     = '0;
    fi.in_last     = 1'b0;
    fi.fc_all_end  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");

    // fc_all_end in IDLE is ignored
    fi.fc_all_end = 1'b1;
    step();
    fi.fc_all_end = 1'b0;
    check("idle_all_end_done", {31'b0, fi.frame_done}, 32'd0);
    check("idle_all_end_busy", {31'b0, fi.busy}, 32'd0);

    // Nominal frame
    cur = nom;
    start_frame();
    load_beats(14, 1'b0);
    complete_frame();

    // ReLU, with the RELU=0 instance checked in lockstep
    cur = relu_v;
    chk_nr = 1'b1;
    start_frame();
    load_beats(14, 1'b0);
    chk_nr = 1'b0;
    complete_frame();

    // Gapped stream
    cur = nom;
    start_frame();
    load_beats(14, 1'b1);
    complete_frame();

    // Early end on beat 5
    cur = nom;
    cur[5].last = 1'b1;
    start_frame();
    load_beats(6, 1'b0);
    check("early_busy", {31'b0, fi.busy}, 32'd0);
    check("early_err", {31'b0, fi.err_len}, 32'd1);
    check("early_enable", {31'b0, fi.fc_enable}, 32'd0);
    step();
    step();
    check("early_no_enable", {31'b0, fi.fc_enable}, 32'd0);
    check("early_no_done", {31'b0, fi.frame_done}, 32'd0);
    check("early_err_sticky", {31'b0, fi.err_len}, 32'd1);

    // Next frame clears err_len; 14 beats without in_last set it again
    start_frame();
    check("err_cleared", {31'b0, fi.err_len}, 32'd0);
    cur = nom;
    cur[13].last = 1'b0;
    load_beats(14, 1'b0);
    check("nolast_err", {31'b0, fi.err_len}, 32'd1);
    complete_frame();
    check("nolast_err_kept", {31'b0, fi.err_len}, 32'd1);

    // Reset after 4 accepts
    cur = nom;
    start_frame();
    load_beats(4, 1'b0);
    reset = 1'b1;
    #1;
    check_all_zero("rst_load");
    check("rst_load_pending", exp_q.size(), 32'd1);
    exp_q.delete();
    step();
    reset = 1'b0;

    // Reset during RUN
    cur = nom;
    start_frame();
    load_beats(14, 1'b0);
    step();
    check("pre_rst_enable", {31'b0, fi.fc_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_run");
    step();
    reset = 1'b0;

    // Following full frame starts at address 0
    cur = nom;
    start_frame();
    load_beats(14, 1'b0);
    complete_frame();

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
